// File: rtl/fpaddsub_normalize_pipe_pkg.sv
// Shared FPAddSub definitions: operand widths and the derived normalizer widths.
// MANTISSA / EXPONENT / DWIDTH may be overridden on the command line.
`ifndef MANTISSA
`define MANTISSA 10
`endif
`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef DWIDTH
`define DWIDTH (1 + `EXPONENT + `MANTISSA)
`endif

package fpaddsub_normalize_pipe_pkg;

    localparam int unsigned MANT  = `MANTISSA;
    localparam int unsigned EXPW  = `EXPONENT;
    localparam int unsigned SUM_W = MANT + 4;
    localparam int unsigned LZC_W = $clog2(SUM_W);

    typedef enum logic [1:0] {
        NORM_CARRY,
        NORM_ZERO,
        NORM_UNDER,
        NORM_LEFT
    } norm_case_e;

    function automatic norm_case_e classify(input logic carry,
                                            input logic zero,
                                            input logic exp_le_lzc);
        if (carry)      return NORM_CARRY;
        if (zero)       return NORM_ZERO;
        if (exp_le_lzc) return NORM_UNDER;
        return NORM_LEFT;
    endfunction

endpackage

// File: rtl/fpaddsub_lzc.sv
// Combinational priority leading-zero counter; an all-zero input yields W.
module fpaddsub_lzc
    import fpaddsub_normalize_pipe_pkg::*;
#(
    parameter int unsigned W     = SUM_W - 1,
    parameter int unsigned CNT_W = LZC_W
) (
    input  logic [W-1:0]     data,
    output logic [CNT_W-1:0] count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = CNT_W'(W);
        for (int unsigned i = 0; i < W; i++) begin
            if (data[i]) count = CNT_W'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fpaddsub_normalize_pipe.sv
// Two-stage normalizer between the mantissa adder and rounding, valid/ready handshake.
// FPADDSUB_NORM_DENORM_EN: produce subnormals on underflow instead of flushing to zero.
module fpaddsub_normalize_pipe
    import fpaddsub_normalize_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    input  logic             in_sticky,
    input  logic [EXPW-1:0]  in_exp,
    input  logic             in_sa,
    input  logic             in_sb,
    input  logic             in_ctrl,
    input  logic             in_maxab,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MANT-1:0]  NormM,
    output logic [EXPW:0]    NormE,
    output logic             G,
    output logic             R,
    output logic             S,
    output logic             ZeroSum,
    output logic             Sa,
    output logic             Sb,
    output logic             Ctrl,
    output logic             MaxAB
);

    logic             s1_valid;
    logic [SUM_W-1:0] s1_sum;
    logic             s1_sticky;
    logic [EXPW-1:0]  s1_exp;
    logic [LZC_W-1:0] s1_lzc;
    logic [3:0]       s1_side;
    logic [LZC_W-1:0] lzc;
    logic             s2_load;

    assign s2_load  = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_load;

    fpaddsub_lzc #(.W(SUM_W - 1), .CNT_W(LZC_W)) u_lzc (
        .data  (in_sum[SUM_W-2:0]),
        .count (lzc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_sticky <= 1'b0;
            s1_exp    <= '0;
            s1_lzc    <= '0;
            s1_side   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum    <= in_sum;
                s1_sticky <= in_sticky;
                s1_exp    <= in_exp;
                s1_lzc    <= lzc;
                s1_side   <= {in_sa, in_sb, in_ctrl, in_maxab};
            end
        end
    end

    logic [EXPW:0]    exp_w;
    logic [EXPW:0]    lzc_w;
    logic [SUM_W-2:0] body;
    logic [SUM_W-2:0] sh;
    logic [LZC_W-1:0] shamt;
    norm_case_e       ncase;
    logic [MANT-1:0]  n_m;
    logic [EXPW:0]    n_e;
    logic             n_g, n_r, n_s, n_z;

    assign exp_w = {1'b0, s1_exp};
    assign lzc_w = (EXPW + 1)'(s1_lzc);
    assign body  = s1_sum[SUM_W-2:0];
    assign ncase = classify(s1_sum[SUM_W-1], s1_sum == '0, exp_w <= lzc_w);

    // The left-shift path supplies the defaults; other cases override them.
    always_comb begin
        shamt = s1_lzc;
`ifdef FPADDSUB_NORM_DENORM_EN
        if (ncase == NORM_UNDER) shamt = (s1_exp == '0) ? '0 : LZC_W'(exp_w - 1'b1);
`endif
        sh  = body << shamt;
        n_m = sh[SUM_W-3:2];
        n_g = sh[1];
        n_r = sh[0];
        n_s = s1_sticky;
        n_z = 1'b0;
        n_e = exp_w - lzc_w;
        case (ncase)
            NORM_CARRY: begin
                n_e = exp_w + 1'b1;
                n_m = s1_sum[SUM_W-2:3];
                n_g = s1_sum[2];
                n_r = s1_sum[1];
                n_s = s1_sum[0] | s1_sticky;
            end
            NORM_ZERO: begin
                n_e = '0;
                n_m = '0;
                n_g = 1'b0;
                n_r = 1'b0;
                n_z = 1'b1;
            end
            NORM_UNDER: begin
`ifdef FPADDSUB_NORM_DENORM_EN
                n_e = '0;
`else
                n_e = '0;
                n_m = '0;
                n_g = 1'b0;
                n_r = 1'b0;
                n_s = 1'b0;
                n_z = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            NormM     <= '0;
            NormE     <= '0;
            G         <= 1'b0;
            R         <= 1'b0;
            S         <= 1'b0;
            ZeroSum   <= 1'b0;
            {Sa, Sb, Ctrl, MaxAB} <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                NormM   <= n_m;
                NormE   <= n_e;
                G       <= n_g;
                R       <= n_r;
                S       <= n_s;
                ZeroSum <= n_z;
                {Sa, Sb, Ctrl, MaxAB} <= s1_side;
            end
        end
    end

endmodule

// File: tb/tb_fpaddsub_normalize_pipe.sv
// Self-checking bench for fpaddsub_normalize_pipe (half precision defaults).
// Honours FPADDSUB_NORM_DENORM_EN when choosing underflow expectations.
module tb_fpaddsub_normalize_pipe;
    import fpaddsub_normalize_pipe_pkg::*;

    localparam int unsigned OW = MANT + EXPW + 1 + 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             in_sticky;
    logic [EXPW-1:0]  in_exp;
    logic             in_sa, in_sb, in_ctrl, in_maxab;
    logic             out_valid;
    logic             out_ready;
    logic [MANT-1:0]  NormM;
    logic [EXPW:0]    NormE;
    logic             G, R, S, ZeroSum;
    logic             Sa, Sb, Ctrl, MaxAB;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fpaddsub_normalize_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_sticky (in_sticky),
        .in_exp    (in_exp),
        .in_sa     (in_sa),
        .in_sb     (in_sb),
        .in_ctrl   (in_ctrl),
        .in_maxab  (in_maxab),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .NormM     (NormM),
        .NormE     (NormE),
        .G         (G),
        .R         (R),
        .S         (S),
        .ZeroSum   (ZeroSum),
        .Sa        (Sa),
        .Sb        (Sb),
        .Ctrl      (Ctrl),
        .MaxAB     (MaxAB)
    );

    function automatic logic [OW-1:0] pack(input int unsigned m, input int unsigned ne,
                                           input int unsigned g, input int unsigned r,
                                           input int unsigned s, input int unsigned z,
                                           input logic [3:0] side);
        logic [MANT-1:0] mm;
        logic [EXPW:0]   ee;
        mm = MANT'(m);
        ee = (EXPW + 1)'(ne);
        return {mm, ee, g[0], r[0], s[0], z[0], side};
    endfunction

    // Arithmetic reference: find the leading one, shift, and adjust the exponent.
    function automatic logic [OW-1:0] model(input logic [SUM_W-1:0] sum, input logic st,
                                            input logic [EXPW-1:0] e, input logic [3:0] side);
        int unsigned s, ex, body, msb, lz, sh, m, ne, g, r, sk, z;
`ifdef FPADDSUB_NORM_DENORM_EN
        int unsigned k;
`endif
        s = sum; ex = e; body = s % (1 << (SUM_W - 1));
        msb = 0; lz = 0; sh = 0; m = 0; ne = 0; g = 0; r = 0; sk = 0; z = 0;
        if (s >= (1 << (SUM_W - 1))) begin
            ne = ex + 1;
            m  = (s >> 3) % (1 << MANT);
            g  = (s >> 2) % 2;
            r  = (s >> 1) % 2;
            sk = (s % 2) | st;
        end else if (s == 0) begin
            z  = 1;
            sk = st;
        end else begin
            while ((body >> (msb + 1)) != 0) msb++;
            lz = (SUM_W - 2) - msb;
            if (ex > lz) begin
                sh = body << lz;
                ne = ex - lz;
            end else begin
`ifdef FPADDSUB_NORM_DENORM_EN
                k  = (ex == 0) ? 0 : ex - 1;
                sh = body << k;
                ne = 0;
`else
                z = 1;
`endif
            end
            if (z == 0) begin
                m  = (sh >> 2) % (1 << MANT);
                g  = (sh >> 1) % 2;
                r  = sh % 2;
                sk = st;
            end
        end
        return pack(m, ne, g, r, sk, z, side);
    endfunction

    function automatic logic [OW-1:0] obs();
        return {NormM, NormE, G, R, S, ZeroSum, Sa, Sb, Ctrl, MaxAB};
    endfunction

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic set_in(input logic [SUM_W-1:0] sum, input logic st,
                          input logic [EXPW-1:0] e, input logic [3:0] side);
        in_sum = sum;
        in_sticky = st;
        in_exp = e;
        {in_sa, in_sb, in_ctrl, in_maxab} = side;
    endtask

    task automatic rand_in();
        logic [SUM_W-1:0] s;
        logic [EXPW-1:0]  e;
        case ($urandom_range(0, 5))
            0: begin s = SUM_W'($urandom); s[SUM_W-1] = 1'b1; end
            1: s = '0;
            2: s = SUM_W'(1) << $urandom_range(0, SUM_W - 2);
            3: s = SUM_W'($urandom) >> $urandom_range(1, SUM_W - 1);
            default: s = SUM_W'($urandom);
        endcase
        case ($urandom_range(0, 4))
            0: e = '0;
            1: e = '1;
            default: e = EXPW'($urandom);
        endcase
        set_in(s, 1'($urandom), e, 4'($urandom));
    endtask

    // One beat through an empty pipe: accepted at once, visible two cycles later.
    task automatic run_one(input string tag, input logic [SUM_W-1:0] sum, input logic st,
                           input logic [EXPW-1:0] e, input logic [3:0] side,
                           input logic [OW-1:0] expected);
        @(negedge clk);
        set_in(sum, st, e, side);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 check({tag, "/accept"}, 64'(in_ready), 64'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "/lat1"}, 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        #1 check({tag, "/valid"}, 64'(out_valid), 64'(1'b1));
        check(tag, 64'(obs()), 64'(expected));
    endtask

    // mode 0: 3-cycle backpressure; mode 1: random gaps/stalls; mode 2: back-to-back.
    task automatic run_stream(input string tag, input int nbeats, input int mode);
        logic [OW-1:0] q[$];
        logic [OW-1:0] held;
        logic          hold;
        int            sent, emitted, cyc, acc_at_drop;
        hold = 1'b0; held = '0; sent = 0; emitted = 0; acc_at_drop = -1;
        for (cyc = 0; emitted < nbeats && cyc < 20 * nbeats + 50; cyc++) begin
            @(negedge clk);
            if (sent < nbeats && (mode != 1 || $urandom_range(0, 3) != 0)) begin
                rand_in();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            case (mode)
                0: out_ready = (cyc >= 3);
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
            #1;
            if (hold) check({tag, "/hold"}, 64'(obs()), 64'(held));
            if (mode == 0 && !in_ready && acc_at_drop < 0) acc_at_drop = sent;
            if (in_valid && in_ready) begin
                q.push_back(model(in_sum, in_sticky, in_exp, {in_sa, in_sb, in_ctrl, in_maxab}));
                sent++;
            end
            if (out_valid && out_ready) begin
                check({tag, "/expected_beat"}, 64'(q.size() != 0), 64'(1'b1));
                if (q.size() != 0) check({tag, "/beat"}, 64'(obs()), 64'(q.pop_front()));
                emitted++;
            end
            hold = out_valid && !out_ready;
            held = obs();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check({tag, "/count"}, 64'(emitted), 64'(nbeats));
        check({tag, "/drain"}, 64'(q.size()), 64'(0));
        if (mode == 0) check({tag, "/drop_after"}, 64'(acc_at_drop), 64'(2));
        if (mode == 2) check({tag, "/rate"}, 64'(cyc), 64'(nbeats + 2));
        @(negedge clk);
        #1 check({tag, "/empty"}, 64'(out_valid), 64'(1'b0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] sd;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_in('0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        #1 check("reset", 64'({out_valid, in_ready, obs()}), 64'({1'b0, 1'b1, {OW{1'b0}}}));
        rst = 1'b0;

        sd = 4'($urandom);
        run_one("carry", 14'b11_0000000001_01, 1'b0, 5'd15, sd, pack('h200, 16, 1, 0, 1, 0, sd));
        sd = 4'($urandom);
        run_one("carry_ovf", 14'h2000, 1'b0, 5'd31, sd, pack(0, 32, 0, 0, 0, 0, sd));
        sd = 4'($urandom);
        run_one("cancel", 14'h0004, 1'b0, 5'd20, sd, pack(0, 10, 0, 0, 0, 0, sd));
        sd = 4'($urandom);
        run_one("zero", 14'h0000, 1'b1, 5'd9, sd, pack(0, 0, 0, 0, 1, 1, sd));
        sd = 4'($urandom);
        run_one("noshift", 14'b01_0000000000_11, 1'b1, 5'd7, sd, pack(0, 7, 1, 1, 1, 0, sd));
        sd = 4'($urandom);
        run_one("shift1", 14'h0FFF, 1'b0, 5'd3, sd, pack('h3FF, 2, 1, 0, 0, 0, sd));
        sd = 4'($urandom);
        run_one("exp_gt_lzc", 14'h0004, 1'b0, 5'd11, sd, pack(0, 1, 0, 0, 0, 0, sd));
`ifdef FPADDSUB_NORM_DENORM_EN
        sd = 4'($urandom);
        run_one("underflow", 14'h0004, 1'b1, 5'd5, sd, pack('h010, 0, 0, 0, 1, 0, sd));
        sd = 4'($urandom);
        run_one("uf_exp_eq_lzc", 14'h0004, 1'b0, 5'd10, sd, pack('h200, 0, 0, 0, 0, 0, sd));
        sd = 4'($urandom);
        run_one("uf_exp0", 14'h0004, 1'b0, 5'd0, sd, pack('h001, 0, 0, 0, 0, 0, sd));
`else
        sd = 4'($urandom);
        run_one("underflow", 14'h0004, 1'b1, 5'd5, sd, pack(0, 0, 0, 0, 0, 1, sd));
        sd = 4'($urandom);
        run_one("uf_exp_eq_lzc", 14'h0004, 1'b0, 5'd10, sd, pack(0, 0, 0, 0, 0, 1, sd));
        sd = 4'($urandom);
        run_one("uf_exp0", 14'h0004, 1'b0, 5'd0, sd, pack(0, 0, 0, 0, 0, 1, sd));
`endif

        run_stream("backpressure", 4, 0);
        run_stream("random", 200, 1);
        run_stream("full_rate", 64, 2);

        // Fill both stages, then reset with them full.
        @(negedge clk);
        out_ready = 1'b0;
        rand_in();
        in_valid = 1'b1;
        @(negedge clk);
        rand_in();
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("rst/full", 64'({out_valid, in_ready}), 64'(2'b10));
        rst = 1'b1;
        @(negedge clk);
        #1 check("rst/flush", 64'({out_valid, in_ready, obs()}), 64'({1'b0, 1'b1, {OW{1'b0}}}));
        rst = 1'b0;
        sd = 4'($urandom);
        run_one("post_rst", 14'h1000, 1'b0, 5'd1, sd, pack(0, 1, 0, 0, 0, 0, sd));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
